// File: rtl/fisqrt_wb_pkg.sv
// Shared register map, bit positions and types for the fastInvSqrt Wishbone FIFO wrapper.
package fisqrt_wb_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int unsigned ST_OVF        = 17;
    localparam int unsigned ST_UDF        = 18;
    localparam int unsigned CTRL_SOFT_CLR = 0;
    localparam int unsigned CTRL_IRQ_EN   = 1;

    typedef struct packed {
        logic [10:0] rsvd;
        logic        res_empty;
        logic        req_full;
        logic        udf;
        logic        ovf;
        logic        busy;
        logic [7:0]  res_count;
        logic [7:0]  req_count;
    } status_t;

    typedef enum logic [1:0] {
        SEQ_RST,
        SEQ_RUN,
        SEQ_CLR0,
        SEQ_CLR1
    } seq_state_t;

endpackage

// File: rtl/fastInvSqrt.sv
// Bit-serial fixed-point 1/sqrt(x) core: largest y with y*y*x <= 1.0 in Qm.n, one bit per cycle.
module fastInvSqrt #(
    parameter int unsigned INT_WIDTH   = 12,
    parameter int unsigned FRACT_WIDTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                valid_in,
    output logic                                ready_in,
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0]    data_in,
    output logic                                valid_out,
    input  logic                                ready_out,
    output logic [INT_WIDTH+FRACT_WIDTH-1:0]    data_out
);

    localparam int unsigned DW = INT_WIDTH + FRACT_WIDTH;
    localparam int unsigned PW = 3 * DW;
    localparam int unsigned BW = $clog2(DW);
    localparam logic [PW-1:0] ONE3 = PW'(1) << (3 * FRACT_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [DW-1:0] trial;
    logic [BW-1:0] bit_idx;
    logic [PW-1:0] prod;
    logic          accept;

    assign data_out = y;

    always_comb begin
        state_nxt = state;
        accept    = valid_in && ready_in;
        trial     = y | (DW'(1) << bit_idx);
        prod      = PW'(trial) * PW'(trial) * PW'(x);
        case (state)
            S_IDLE:  if (accept) state_nxt = S_CALC;
            S_CALC:  if (bit_idx == '0) state_nxt = S_DONE;
            S_DONE:  if (ready_out) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ready_in  <= 1'b1;
            valid_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            ready_in  <= state_nxt == S_IDLE;
            valid_out <= state_nxt == S_DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            bit_idx <= '0;
        end else if (state == S_IDLE) begin
            if (accept) begin
                x       <= data_in;
                y       <= '0;
                bit_idx <= BW'(DW - 1);
            end
        end else if (state == S_CALC) begin
            if (prod <= ONE3) begin
                y <= trial;
            end
            bit_idx <= bit_idx - BW'(1);
        end
    end

endmodule

// File: rtl/fisqrt_sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head and a synchronous flush.
module fisqrt_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    rptr_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic             do_push;
    logic             do_pop;

    assign full  = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
    assign empty = wptr == rptr;
    assign count = wptr - rptr;

    // Head for the next cycle; bypass din when the slot being written becomes the head.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rptr_nxt = rptr + PW'(do_pop);
        dout_nxt = mem[rptr_nxt[AW-1:0]];
        if (do_push && (rptr_nxt == wptr)) begin
            dout_nxt = din;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            dout <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + PW'(do_push);
            rptr <= rptr_nxt;
            dout <= dout_nxt;
        end
    end

endmodule

// File: rtl/fast_inv_sqrt_wb_fifo.sv
// Wishbone slave streaming operands through request/result FIFOs around the fastInvSqrt core.
module fast_inv_sqrt_wb_fifo #(
    parameter int unsigned INT_W      = 12,
    parameter int unsigned FRAC_W     = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    output logic        irq_o
);

    import fisqrt_wb_pkg::*;

    localparam int unsigned DATA_W = INT_W + FRAC_W;
    localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [1:0]        reg_sel;
    logic              fire;
    logic              wr_data;
    logic              rd_data;
    logic              wr_status;
    logic              wr_ctrl;
    logic              soft_clr;
    logic              flush;
    logic              core_rst;
    logic              busy;
    logic              ovf;
    logic              udf;
    logic              irq_en;
    logic              req_full;
    logic              req_empty;
    logic              res_full;
    logic              res_empty;
    logic [CW-1:0]     req_count;
    logic [CW-1:0]     res_count;
    logic [DATA_W-1:0] req_dout;
    logic [DATA_W-1:0] res_dout;
    logic [DATA_W-1:0] core_dout;
    logic              core_ready_in;
    logic              core_valid_out;
    logic              in_hs;
    logic              out_hs;
    logic [31:0]       rdata;
    status_t           status;
    logic              unused;

    assign unused = ^{adr_i[31:4], adr_i[1:0], dat_i};

    // Bus decode; every side effect is qualified by the firing strobe.
    always_comb begin
        reg_sel   = adr_i[3:2];
        fire      = cyc_i && stb_i && !ack_o;
        wr_data   = fire && we_i && (reg_sel == REG_DATA);
        rd_data   = fire && !we_i && (reg_sel == REG_DATA);
        wr_status = fire && we_i && (reg_sel == REG_STATUS);
        wr_ctrl   = fire && we_i && (reg_sel == REG_CTRL);
        soft_clr  = wr_ctrl && dat_i[CTRL_SOFT_CLR];
        in_hs     = !req_empty && core_ready_in && !core_rst;
        out_hs    = core_valid_out && !res_full;
        flush     = state == SEQ_CLR0;
    end

    fisqrt_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_data && !req_full),
        .pop   (in_hs),
        .flush (flush),
        .din   (dat_i[DATA_W-1:0]),
        .dout  (req_dout),
        .full  (req_full),
        .empty (req_empty),
        .count (req_count)
    );

    fisqrt_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (out_hs),
        .pop   (rd_data && !res_empty),
        .flush (flush),
        .din   (core_dout),
        .dout  (res_dout),
        .full  (res_full),
        .empty (res_empty),
        .count (res_count)
    );

    fastInvSqrt #(.INT_WIDTH(INT_W), .FRACT_WIDTH(FRAC_W)) u_core (
        .clk       (clk),
        .rst       (core_rst),
        .valid_in  (!req_empty),
        .ready_in  (core_ready_in),
        .data_in   (req_dout),
        .valid_out (core_valid_out),
        .ready_out (!res_full),
        .data_out  (core_dout)
    );

    // Soft-clear sequencer: flush in the first cycle, core reset held for two cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            SEQ_RST:  state_nxt = SEQ_RUN;
            SEQ_RUN:  state_nxt = SEQ_RUN;
            SEQ_CLR0: state_nxt = SEQ_CLR1;
            SEQ_CLR1: state_nxt = SEQ_RUN;
            default:  state_nxt = SEQ_RUN;
        endcase
        if (soft_clr) begin
            state_nxt = SEQ_CLR0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SEQ_RST;
            core_rst <= 1'b1;
        end else begin
            state    <= state_nxt;
            core_rst <= state_nxt != SEQ_RUN;
        end
    end

    always_comb begin
        status           = '0;
        status.req_count = 8'(req_count);
        status.res_count = 8'(res_count);
        status.busy      = busy;
        status.ovf       = ovf;
        status.udf       = udf;
        status.req_full  = req_full;
        status.res_empty = res_empty;
        case (reg_sel)
            REG_DATA:   rdata = res_empty ? 32'd0 : 32'(res_dout);
            REG_STATUS: rdata = status;
            REG_CTRL:   rdata = {30'd0, irq_en, 1'b0};
            default:    rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_o  <= 1'b0;
            dat_o  <= '0;
            irq_o  <= 1'b0;
            irq_en <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            ack_o <= fire;
            if (fire) begin
                dat_o <= rdata;
            end
            if (wr_ctrl) begin
                irq_en <= dat_i[CTRL_IRQ_EN];
            end
            // A new error in the same cycle as its W1C keeps the flag set.
            ovf   <= (wr_data && req_full) || (ovf && !(wr_status && dat_i[ST_OVF]));
            udf   <= (rd_data && res_empty) || (udf && !(wr_status && dat_i[ST_UDF]));
            irq_o <= irq_en && !res_empty;
            if (flush) begin
                busy <= 1'b0;
            end else if (in_hs) begin
                busy <= 1'b1;
            end else if (out_hs) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fast_inv_sqrt_wb_fifo.sv
// Self-checking bench for fast_inv_sqrt_wb_fifo: vector table, random streams, corner sequences.
module tb_fast_inv_sqrt_wb_fifo;

    localparam int unsigned DEPTH = 4;
    localparam real SCALE = 16.0;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        we_i;
    logic        stb_i;
    logic        cyc_i;
    logic        ack_o;
    logic        irq_o;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] op;
        logic [15:0] res;
    } vec_t;

    fast_inv_sqrt_wb_fifo #(.INT_W(12), .FRAC_W(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .we_i  (we_i),
        .stb_i (stb_i),
        .cyc_i (cyc_i),
        .ack_o (ack_o),
        .irq_o (irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    // Reference: floor(1/sqrt(x)) in Q12.4, saturated to 16 bits.
    function automatic int model_isqrt(input int x);
        real r;
        r = SCALE * $sqrt(SCALE / real'(x));
        if (r > 65535.0) return 65535;
        return int'($floor(r));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_res(input string name, input logic [31:0] act, input int exp);
        int a;
        a = int'(act);
        vectors++;
        if ((^act === 1'bx) || (a > exp + 1) || (a + 1 < exp)) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h +/-1", name, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] r);
        int k;
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!ack_o && k < 4);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        check("ack", 32'(ack_o), 32'd1);
        r = dat_o;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus(1'b1, a, d, r);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r);
        bus(1'b0, a, 32'd0, r);
    endtask

    task automatic poll_res(input int n);
        logic [31:0] s;
        int k;
        k = 0;
        do begin
            rd(32'h4, s);
            k++;
        end while (int'(s[15:8]) != n && k < 300);
        check("poll res_count", 32'(s[15:8]), 32'(n));
    endtask

    task automatic poll_status(input string name, input logic [31:0] target);
        logic [31:0] s;
        int k;
        k = 0;
        do begin
            rd(32'h4, s);
            k++;
        end while (s !== target && k < 300);
        check(name, s, target);
    endtask

    task automatic poll_nonempty();
        logic [31:0] s;
        int k;
        k = 0;
        do begin
            rd(32'h4, s);
            k++;
        end while (s[20] !== 1'b0 && k < 300);
        check("poll res_empty", 32'(s[20]), 32'd0);
    endtask

    initial begin
        vec_t        tbl [8];
        logic [31:0] r;
        logic [31:0] op;
        int          q [$];
        int          n;

        tbl[0] = '{16'h0040, 16'h0008};
        tbl[1] = '{16'h0010, 16'h0010};
        tbl[2] = '{16'h0100, 16'h0004};
        tbl[3] = '{16'h0001, 16'h0040};
        tbl[4] = '{16'h0400, 16'h0002};
        tbl[5] = '{16'h0024, 16'h000A};
        tbl[6] = '{16'h0004, 16'h0020};
        tbl[7] = '{16'h1000, 16'h0001};

        rst = 1'b1; adr_i = '0; dat_i = '0; we_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ack_o", 32'(ack_o), 32'd0);
        check("reset dat_o", dat_o, 32'd0);
        check("reset irq_o", 32'(irq_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd(32'h4, r); check("reset status", r, 32'h0010_0000);
        rd(32'h8, r); check("reset ctrl", r, 32'd0);
        rd(32'hC, r); check("rsvd read", r, 32'd0);

        // Single-shot table
        foreach (tbl[i]) begin
            wr(32'h0, 32'(tbl[i].op));
            poll_res(1);
            rd(32'h0, r);
            check_res($sformatf("table[%0d]", i), r, int'(tbl[i].res));
            rd(32'h4, r);
            check("status after pop", r, 32'h0010_0000);
        end

        // Back-to-back ordering
        wr(32'h0, 32'h0010); wr(32'h0, 32'h0040); wr(32'h0, 32'h0100);
        poll_res(3);
        rd(32'h0, r); check_res("b2b 0", r, 16);
        rd(32'h0, r); check_res("b2b 1", r, 8);
        rd(32'h0, r); check_res("b2b 2", r, 4);

        // Random streams
        for (int round = 0; round < 8; round++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                op = 32'($urandom_range(1, 16'hFFFF));
                wr(32'h0, op);
                q.push_back(int'(op));
            end
            poll_res(n);
            for (int i = 0; i < n; i++) begin
                rd(32'h0, r);
                check_res($sformatf("rand r%0d i%0d", round, i), r, model_isqrt(q.pop_front()));
            end
        end

        // Overflow with the core stalled on a full result FIFO
        for (int i = 0; i < DEPTH; i++) begin
            op = 32'($urandom_range(1, 16'hFFFF));
            wr(32'h0, op);
            q.push_back(int'(op));
        end
        poll_res(DEPTH);
        op = 32'($urandom_range(1, 16'hFFFF));
        wr(32'h0, op);
        q.push_back(int'(op));
        poll_status("core holding", 32'h0001_0400);
        repeat (40) @(posedge clk);
        for (int i = 0; i < DEPTH + 2; i++) begin
            op = 32'($urandom_range(1, 16'hFFFF));
            wr(32'h0, op);
            if (i < DEPTH) q.push_back(int'(op));
        end
        rd(32'h4, r); check("ovf status", r, 32'h000B_0404);
        wr(32'h4, 32'h0002_0000);
        rd(32'h4, r); check("ovf cleared", r, 32'h0009_0404);
        n = q.size();
        for (int i = 0; i < n; i++) begin
            poll_nonempty();
            rd(32'h0, r);
            check_res($sformatf("ovf drain %0d", i), r, model_isqrt(q.pop_front()));
        end
        poll_status("ovf drained", 32'h0010_0000);

        // Underflow, then interrupt
        rd(32'h0, r); check("udf data", r, 32'd0);
        rd(32'h4, r); check("udf status", r, 32'h0014_0000);
        wr(32'h4, 32'h0004_0000);
        rd(32'h4, r); check("udf cleared", r, 32'h0010_0000);
        wr(32'h8, 32'h2);
        rd(32'h8, r); check("ctrl irq_en", r, 32'h2);
        check("irq idle", 32'(irq_o), 32'd0);
        wr(32'h0, 32'h0040);
        poll_res(1);
        @(posedge clk); #1;
        check("irq pending", 32'(irq_o), 32'd1);
        rd(32'h0, r); check_res("irq result", r, 8);
        repeat (2) @(posedge clk); #1;
        check("irq after pop", 32'(irq_o), 32'd0);
        wr(32'h8, 32'h0);

        // Soft clear mid-computation
        wr(32'h0, 32'h0010); wr(32'h0, 32'h0040); wr(32'h0, 32'h0100);
        repeat (6) @(posedge clk);
        wr(32'h8, 32'h1);
        repeat (3) @(posedge clk);
        rd(32'h4, r); check("soft_clr status", r, 32'h0010_0000);
        rd(32'h8, r); check("soft_clr ctrl", r, 32'd0);
        repeat (60) @(posedge clk);
        rd(32'h4, r); check("no stale result", r, 32'h0010_0000);
        wr(32'h0, 32'h0040);
        poll_res(1);
        rd(32'h0, r); check_res("after soft_clr", r, 8);

        // Async reset while busy with results queued
        wr(32'h8, 32'h2);
        wr(32'h0, 32'h0010); wr(32'h0, 32'h0100);
        poll_res(2);
        wr(32'h0, 32'h0040);
        repeat (3) @(posedge clk); #1;
        check("irq before rst", 32'(irq_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst ack_o", 32'(ack_o), 32'd0);
        check("rst dat_o", dat_o, 32'd0);
        check("rst irq_o", 32'(irq_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd(32'h4, r); check("status after rst", r, 32'h0010_0000);
        rd(32'h8, r); check("ctrl after rst", r, 32'd0);
        wr(32'h0, 32'h0100);
        poll_res(1);
        rd(32'h0, r); check_res("after rst", r, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
